rc5_crypt_param: RTL and testbench
==================================

// Module: rc5_crypt_param
// PURPOSE
//  Parametrised RC5-W/R block cipher engine; encrypts or decrypts one 2W-bit block per transaction.
//  Round keys S[0..2R+1] are held in an internal loadable key table; no on-chip key expansion.
//  Iterative datapath: one half-round per clock. Valid/ready streaming on both sides.
//  Sits between the host register interface and the data path; next generation of the 16-bit fixed-key encryptor.
// PARAMETERS
//  W      16   word width in bits; legal 8, 16, 32; block = 2W bits
//  R      12   round count; legal 1..255
//  NK     2R+2 (localparam) key-table depth; KAW = $clog2(NK) address width
// PORTS
//  clock      in   1    rising-edge clock
//  reset      in   1    synchronous, active-high reset
//  key_we     in   1    write strobe for key table
//  key_addr   in   KAW  key-table index 0..NK-1; out-of-range writes ignored
//  key_wdata  in   W    round-key word
//  in_valid   in   1    input block valid
//  in_ready   out  1    engine can accept a block
//  in_mode    in   1    0 = encrypt, 1 = decrypt; sampled with block
//  in_data    in   2W   block {A,B}; A = in_data[2W-1:W]
//  out_valid  out  1    result valid; held until accepted
//  out_ready  in   1    downstream accepts result
//  out_data   out  2W   result {A,B}
//  busy       out  1    high from accept until result handed off
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, out_data=0, busy=0, round counter=0; key table NOT cleared.
//  Reset mid-operation aborts the block; no output produced.
//  Arithmetic: all +/- modulo 2^W; rotate amount = low log2(W) bits of the other word; rotate by 0 = identity.
//  FSM: IDLE -> INIT -> (HALF_1 -> HALF_2) x R -> DONE -> IDLE.
//  IDLE: in_ready=1; on in_valid: latch A,B,mode; busy=1; go INIT.
//  Encrypt: INIT A+=S0, B+=S1, i=1.
//   HALF_1 A=rotl(A^B,B)+S[2i]. HALF_2 B=rotl(B^A,A)+S[2i+1].
//   After HALF_2: i==R -> DONE; else i++.
//  Decrypt: INIT i=R, A,B unchanged.
//   HALF_1 B=rotr(B-S[2i+1],A)^A. HALF_2 A=rotr(A-S[2i],B)^B.
//   After HALF_2: i==1 -> FINAL (B-=S1, A-=S0) -> DONE; else i--.
//   Decrypt latency equalised: encrypt inserts one idle FINAL cycle.
//   Latency: out_valid rises exactly 2R+3 clocks after the accepting edge, both modes.
//  DONE: out_valid=1, out_data={A,B} stable; on out_ready -> IDLE, out_valid=0, busy=0 next cycle.
//   in_ready=0 throughout DONE; no new block is accepted in the hand-off cycle.
//  Backpressure: out_ready low holds DONE indefinitely; out_data and out_valid must not change.
//  Key writes: applied in any state. A write while busy=1 may corrupt the current block; software must not do it.
//   The bench checks only that such a write is stored.
//  Key read and write to the same entry in one cycle: the round uses the old value.
//  in_mode and in_data are ignored while in_ready=0.
// STRUCTURE
//  rc5_pkg:
//   - state enum {IDLE, INIT, HALF_1, HALF_2, FINAL, DONE}
//   - mode enum {ENC, DEC}
//   - parameterised rotl/rotr functions (W-generic, amount masked to log2(W) bits)
//  rc5_half_round (combinational sub-module):
//   - inputs: x, y, key, mode; output: next word
//   - computes the enc or dec half-round
//   - instantiated once, muxed A/B by state
//  Top level: FSM, round counter, A/B registers, key table (flop array, NK x W), handshake.
// TESTING
//  1. W=8,R=1, S={20,10,FF,FF}, enc in_data=16'h0000 -> out_data=16'h2F9E, out_valid 5 clocks after accept.
//  2. Same keys, dec in_data=16'h2F9E -> out_data=16'h0000; decrypt latency equals encrypt latency.
//  3. W=32,R=12, all-zero key table as expanded by the RC5 reference key schedule:
//     enc 64'h00000000_00000000 -> 64'h21A5DBEE_154B8F6D (byte-ordered per RC5 vectors); dec round-trips.
//  4. Hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, busy=1;
//     release -> one transfer, IDLE next cycle.
//  5. Assert reset during HALF_1 of round 3 -> next cycle: in_ready=1, out_valid=0, busy=0;
//     key table intact, next block correct.
//  6. Random mode/data/keys, 1000 blocks, random in_valid/out_ready gaps:
//     scoreboard against C model; enc->dec round-trip identity.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared types and W-generic rotate helpers for the RC5 engine.
package rc5_pkg;

    localparam int unsigned MAXW = 32;
    localparam int unsigned AMTW = 5;

    typedef enum logic [2:0] {IDLE, INIT, HALF_1, HALF_2, FINAL, DONE} state_e;
    typedef enum logic {ENC = 1'b0, DEC = 1'b1} mode_e;

    // Rotate the low w bits of x; amount is masked to log2(w) bits, upper bits return zero.
    function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] x,
                                             input logic [AMTW-1:0] amt,
                                             input int unsigned     w);
        logic [MAXW-1:0] r;
        int unsigned     a;
        r = '0;
        a = 32'(amt) & (w - 1);
        for (int unsigned i = 0; i < MAXW; i++) begin
            if (i < w) r[i] = x[AMTW'((i + w - a) % w)];
        end
        return r;
    endfunction

    function automatic logic [MAXW-1:0] rotr(input logic [MAXW-1:0] x,
                                             input logic [AMTW-1:0] amt,
                                             input int unsigned     w);
        logic [MAXW-1:0] r;
        int unsigned     a;
        r = '0;
        a = 32'(amt) & (w - 1);
        for (int unsigned i = 0; i < MAXW; i++) begin
            if (i < w) r[i] = x[AMTW'((i + a) % w)];
        end
        return r;
    endfunction

endpackage

// File: rtl/rc5_crypt_param_if.sv
// Key-load, input-block and output-block signals of the RC5 engine.
interface rc5_crypt_param_if #(
    parameter int unsigned W = 16,
    parameter int unsigned R = 12
);
    localparam int unsigned KAW = $clog2(2 * R + 2);

    logic             key_we;
    logic [KAW-1:0]   key_addr;
    logic [W-1:0]     key_wdata;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [2*W-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_data;
    logic             busy;

    modport master (
        output key_we, key_addr, key_wdata, in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  key_we, key_addr, key_wdata, in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/rc5_half_round.sv
// One RC5 half-round: enc x' = rotl(x^y, y) + key, dec x' = rotr(x - key, y) ^ y.
module rc5_half_round
    import rc5_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] key,
    input  mode_e        mode,
    output logic [W-1:0] nxt
);
    localparam int unsigned LW = $clog2(W);

    logic [AMTW-1:0] amt;
    logic [W-1:0]    rot_l;
    logic [W-1:0]    rot_r;

    always_comb begin
        amt   = AMTW'(y[LW-1:0]);
        rot_l = W'(rotl(MAXW'(x ^ y), amt, W));
        rot_r = W'(rotr(MAXW'(x - key), amt, W));
        nxt   = (mode == ENC) ? (rot_l + key) : (rot_r ^ y);
    end
endmodule

// File: rtl/rc5_crypt_param.sv
// Iterative RC5-W/R encrypt/decrypt engine, one half-round per clock, loadable round-key table.
module rc5_crypt_param
    import rc5_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned R = 12
) (
    input logic              clock,
    input logic              reset,
    rc5_crypt_param_if.slave bus
);
    localparam int unsigned NK  = 2 * R + 2;
    localparam int unsigned KAW = $clog2(NK);
    localparam int unsigned RW  = 8;

    state_e         state;
    mode_e          mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [RW-1:0]  rnd;
    logic [W-1:0]   key_tbl [NK];

    logic           upd_a;
    logic           last_rnd;
    logic [KAW-1:0] ka;
    logic [KAW-1:0] kb;
    logic [W-1:0]   hx;
    logic [W-1:0]   hy;
    logic [W-1:0]   hk;
    logic [W-1:0]   hr;

    // Key table is never reset; a same-cycle read sees the old entry.
    always_ff @(posedge clock) begin
        if (bus.key_we && (32'(bus.key_addr) < NK)) begin
            key_tbl[bus.key_addr] <= bus.key_wdata;
        end
    end

    // Encrypt HALF_1 and decrypt HALF_2 rewrite A with S[2i]; the other two rewrite B with S[2i+1].
    always_comb begin
        upd_a    = (state == HALF_1) == (mode == ENC);
        ka       = KAW'({rnd, 1'b0});
        kb       = KAW'({rnd, 1'b1});
        hx       = upd_a ? a : b;
        hy       = upd_a ? b : a;
        hk       = upd_a ? key_tbl[ka] : key_tbl[kb];
        last_rnd = (mode == ENC) ? (rnd == RW'(R)) : (rnd == RW'(1));
    end

    rc5_half_round #(.W(W)) u_half (
        .x    (hx),
        .y    (hy),
        .key  (hk),
        .mode (mode),
        .nxt  (hr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mode          <= ENC;
            a             <= '0;
            b             <= '0;
            rnd           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a            <= bus.in_data[2*W-1:W];
                        b            <= bus.in_data[W-1:0];
                        mode         <= mode_e'(bus.in_mode);
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= INIT;
                    end
                end
                INIT: begin
                    if (mode == ENC) begin
                        a   <= a + key_tbl[0];
                        b   <= b + key_tbl[1];
                        rnd <= RW'(1);
                    end else begin
                        rnd <= RW'(R);
                    end
                    state <= HALF_1;
                end
                HALF_1: begin
                    if (upd_a) a <= hr;
                    else       b <= hr;
                    state <= HALF_2;
                end
                HALF_2: begin
                    if (upd_a) a <= hr;
                    else       b <= hr;
                    if (last_rnd) begin
                        state <= FINAL;
                    end else begin
                        state <= HALF_1;
                        rnd   <= (mode == ENC) ? rnd + RW'(1) : rnd - RW'(1);
                    end
                end
                // Decrypt unwhitens here; encrypt idles so both modes share one latency.
                FINAL: begin
                    if (mode == DEC) begin
                        a <= a - key_tbl[0];
                        b <= b - key_tbl[1];
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= {a, b};
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_crypt_param.sv
// Directed and randomised checks of rc5_crypt_param at W=8/R=1 and W=32/R=12.
module tb_rc5_crypt_param;

    logic clk;
    logic reset;
    int   checks = 0;
    int   passed = 0;

    rc5_crypt_param_if #(.W(8),  .R(1))  if8  ();
    rc5_crypt_param_if #(.W(32), .R(12)) if32 ();

    rc5_crypt_param #(.W(8),  .R(1))  dut8  (.clock(clk), .reset(reset), .bus(if8));
    rc5_crypt_param #(.W(32), .R(12)) dut32 (.clock(clk), .reset(reset), .bus(if32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [15:0] din;
        logic [15:0] dout;
    } vec8_t;

    logic [31:0] s32 [26];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] k);
        logic [63:0] v;
        v = {x, x} << k;
        return v[63:32];
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] k);
        logic [63:0] v;
        v = {x, x} >> k;
        return v[31:0];
    endfunction

    function automatic logic [63:0] model32(input logic [63:0] blk, input logic dec);
        logic [31:0] a, b;
        a = blk[63:32];
        b = blk[31:0];
        if (!dec) begin
            a += s32[0];
            b += s32[1];
            for (int i = 1; i <= 12; i++) begin
                a = rol32(a ^ b, b[4:0]) + s32[2*i];
                b = rol32(b ^ a, a[4:0]) + s32[2*i+1];
            end
        end else begin
            for (int i = 12; i >= 1; i--) begin
                b = ror32(b - s32[2*i+1], a[4:0]) ^ a;
                a = ror32(a - s32[2*i], b[4:0]) ^ b;
            end
            b -= s32[1];
            a -= s32[0];
        end
        return {a, b};
    endfunction

    // Reference RC5-32/12 key schedule for a 16-byte all-zero key.
    task automatic zero_key_schedule();
        logic [31:0] l [4];
        logic [31:0] xa, xb;
        int          i, j;
        for (int k = 0; k < 4; k++) l[k] = '0;
        s32[0] = 32'hB7E1_5163;
        for (int k = 1; k < 26; k++) s32[k] = s32[k-1] + 32'h9E37_79B9;
        xa = '0; xb = '0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            xa = rol32(s32[i] + xa + xb, 5'd3);
            s32[i] = xa;
            xb = rol32(l[j] + xa + xb, 5'(xa + xb));
            l[j] = xb;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic load32();
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if32.key_we    = 1'b1;
            if32.key_addr  = 5'(k);
            if32.key_wdata = s32[k];
        end
        @(negedge clk);
        if32.key_we = 1'b0;
    endtask

    task automatic run8(input logic mode, input logic [15:0] din, input logic [15:0] dout, input int idx);
        int n, lat;
        @(negedge clk);
        if8.in_valid = 1'b1;
        if8.in_mode  = mode;
        if8.in_data  = din;
        n = 0;
        while (!if8.in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        if8.in_valid = 1'b0;
        if8.in_data  = ~din;
        lat = 0;
        while (!if8.out_valid && lat < 50) begin @(negedge clk); lat++; end
        check($sformatf("vec%0d latency", idx), 72'(lat), 72'(5));
        check($sformatf("vec%0d data", idx), 72'(if8.out_data), 72'(dout));
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
    endtask

    // Leaves the caller at the falling edge just after the accepting edge.
    task automatic start32(input logic mode, input logic [63:0] din, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        if32.in_valid = 1'b1;
        if32.in_mode  = mode;
        if32.in_data  = din;
        n = 0;
        while (!if32.in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        if32.in_valid = 1'b0;
        if32.in_mode  = ~mode;
        if32.in_data  = {$urandom, $urandom};
    endtask

    task automatic finish32(input logic [63:0] exp, input int hold, input int elapsed,
                            input string name, output logic [63:0] res);
        int lat;
        lat = elapsed;
        while (!if32.out_valid && lat < 200) begin @(negedge clk); lat++; end
        check({name, " latency"}, 72'(lat), 72'(27));
        res = if32.out_data;
        check({name, " data"}, 72'(res), 72'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, " hold"}, 72'({if32.out_valid, if32.in_ready, if32.busy, if32.out_data}),
                  72'({3'b101, exp}));
        end
        if32.out_ready = 1'b1;
        @(negedge clk);
        if32.out_ready = 1'b0;
        check({name, " handoff"}, 72'({if32.out_valid, if32.in_ready, if32.busy}), 72'(3'b010));
    endtask

    initial begin
        vec8_t       tbl [6];
        logic [7:0]  k8 [4];
        logic [63:0] res, res2, pt, exp;
        logic        mode;

        tbl[0] = '{1'b0, 16'h0000, 16'h2F9E};
        tbl[1] = '{1'b1, 16'h2F9E, 16'h0000};
        tbl[2] = '{1'b0, 16'h0102, 16'hCBCD};
        tbl[3] = '{1'b1, 16'hCBCD, 16'h0102};
        tbl[4] = '{1'b0, 16'hFFFF, 16'h0703};
        tbl[5] = '{1'b1, 16'h0703, 16'hFFFF};
        k8[0] = 8'h20; k8[1] = 8'h10; k8[2] = 8'hFF; k8[3] = 8'hFF;

        reset = 1'b1;
        {if8.key_we, if8.key_addr, if8.key_wdata, if8.in_valid, if8.in_mode, if8.in_data, if8.out_ready} = '0;
        {if32.key_we, if32.key_addr, if32.key_wdata, if32.in_valid, if32.in_mode, if32.in_data, if32.out_ready} = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset8", 72'({if8.in_ready, if8.out_valid, if8.busy, if8.out_data}), 72'({3'b100, 16'h0}));
        check("reset32", 72'({if32.in_ready, if32.out_valid, if32.busy, if32.out_data}), 72'({3'b100, 64'h0}));

        // W=8, R=1 hand-computed vectors
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if8.key_we = 1'b1; if8.key_addr = 2'(k); if8.key_wdata = k8[k];
        end
        @(negedge clk);
        if8.key_we = 1'b0;
        for (int v = 0; v < 6; v++) run8(tbl[v].mode, tbl[v].din, tbl[v].dout, v);

        // RC5-32/12/16 zero-key vector; words little-endian from bytes 21A5DBEE 154B8F6D
        zero_key_schedule();
        load32();
        start32(1'b0, 64'h0, 0);
        finish32(64'hEEDBA521_6D8F4B15, 0, 0, "zero key enc", res);
        start32(1'b1, res, 0);
        finish32(64'h0, 0, 0, "zero key dec", res2);

        // Long backpressure in DONE
        pt = 64'h0123_4567_89AB_CDEF;
        start32(1'b0, pt, 1);
        finish32(model32(pt, 1'b0), 10, 0, "backpressure", res);

        // Reset during HALF_1 of round 3
        start32(1'b1, pt, 0);
        repeat (5) @(negedge clk);
        check("busy before abort", 72'({if32.busy, if32.out_valid}), 72'(2'b10));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort", 72'({if32.in_ready, if32.out_valid, if32.busy}), 72'(3'b100));
        pt = 64'hDEAD_BEEF_0BAD_F00D;
        start32(1'b0, pt, 0);
        finish32(model32(pt, 1'b0), 0, 0, "after abort", res);

        // Key writes while busy are stored; out-of-range address ignored
        exp = model32(pt, 1'b0);
        start32(1'b0, pt, 0);
        repeat (2) @(negedge clk);
        check("busy at key write", 72'(if32.busy), 72'(1));
        if32.key_we = 1'b1; if32.key_addr = 5'd0; if32.key_wdata = 32'h1357_9BDF;
        @(negedge clk);
        if32.key_addr = 5'd30; if32.key_wdata = 32'hFFFF_0000;
        @(negedge clk);
        if32.key_we = 1'b0;
        finish32(exp, 0, 4, "during key write", res);
        s32[0] = 32'h1357_9BDF;
        start32(1'b0, pt, 0);
        finish32(model32(pt, 1'b0), 0, 0, "new key0", res);

        // Random keys, modes, data and handshake gaps
        for (int n = 0; n < 1000; n++) begin
            if (n % 250 == 0) begin
                for (int k = 0; k < 26; k++) s32[k] = $urandom;
                load32();
            end
            mode = 1'($urandom_range(0, 1));
            pt   = {$urandom, $urandom};
            start32(mode, pt, int'($urandom_range(0, 2)));
            finish32(model32(pt, mode), int'($urandom_range(0, 2)), 0, $sformatf("rand%0d", n), res);
            if (!mode) begin
                start32(1'b1, res, 0);
                finish32(pt, 0, 0, $sformatf("roundtrip%0d", n), res2);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
